ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Each cycle it captures the execute result: destination address, write enable, write data, and the HI/LO write request.
- It honours the global stall vector and a flush input.
- It holds the execute stage's multi-cycle accumulator state (64-bit partial product plus step counter) across stall cycles, so that madd/msub-style two-cycle operations can resume.

Parameters:
- REG_W, 32, general-purpose register / data width.
- ADDR_W, 5, register-file address width.
- CNT_W, 2, multi-cycle step-counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable = 1'b1`).
- stall  in  6  global stall vector; bit 3 = execute stage stopped, bit 4 = memory stage stopped (`Stop = 1`).
- flush  in  1  pipeline flush (exception/eret); synchronous, highest priority after rst.
- ex_wd  in  ADDR_W  destination register from execute.
- ex_wreg  in  1  register write enable from execute.
- ex_wdata  in  REG_W  result data from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- ex_hi  in  REG_W  HI value to write.
- ex_lo  in  REG_W  LO value to write.
- hilo_i  in  2*REG_W  partial product produced by execute this cycle.
- cnt_i  in  CNT_W  multi-cycle step count produced by execute this cycle.
- mem_wd  out  ADDR_W  registered destination address.
- mem_wreg  out  1  registered write enable.
- mem_wdata  out  REG_W  registered data.
- mem_whilo  out  1  registered HI/LO write enable.
- mem_hi  out  REG_W  registered HI value.
- mem_lo  out  REG_W  registered LO value.
- mem_valid  out  1  high when the memory stage holds a real instruction, low for a bubble.
- hilo_o  out  2*REG_W  held partial product, fed back to execute.
- cnt_o  out  CNT_W  held step count, fed back to execute.

Behaviour:
- Reset (rst=1, asynchronous):
  - mem_wd=0, mem_wreg=WriteDisable(0), mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0.
  - mem_valid=0, hilo_o=0, cnt_o=0.
  - Reset asserted mid multi-cycle operation discards the partial product; no recovery.
- Latency: exactly one cycle from ex_* to mem_*; no combinational path from input to output.
- Priority on each rising edge, first match wins:
  1. flush=1: all mem_* zeroed, mem_valid=0, hilo_o=0, cnt_o=0. Applies regardless of the stall bits.
  2. stall[3]=1 and stall[4]=0 (execute stalled, memory running):
     - Insert a bubble: mem_* zeroed, mem_wreg=0, mem_whilo=0, mem_valid=0.
     - Capture the accumulator: hilo_o<=hilo_i, cnt_o<=cnt_i.
  3. stall[3]=0 (execute advancing):
     - mem_*<=ex_*, mem_valid<=1.
     - Clear the accumulator: hilo_o<=0, cnt_o<=0, so the next instruction starts from step 0.
  4. Otherwise (both stages stalled):
     - All outputs, including mem_valid, hilo_o and cnt_o, hold their values.
- The combination stall[3]=0 with stall[4]=1 is illegal (the stall controller never produces it). The block treats it as case 3. The bench flags it as an assertion.
- The accumulator is captured only in case 2. Its step count therefore advances only while execute is actually stalled on its own multi-cycle operation.
- A bubble never writes: mem_wreg=0 and mem_whilo=0 whenever mem_valid=0.
- Width rules:
  - hilo_o is stored verbatim; no truncation.
  - cnt_o is stored verbatim; execute bounds it, with 2'b10 meaning "second step done". This block does not saturate it.
- Simultaneous flush and stall: flush wins, clearing even the held state.

Decomposition:
- Shared defines package (global `define` include): RstEnable, Stop/NoStop, WriteEnable/WriteDisable, ZeroWord, RegBus, RegAddBus, DoubleRegBus, and the stall-bit indices (STALL_EX=3, STALL_MEM=4).
- No sub-module. A single clocked process plus one small priority-decode of {flush, stall[4], stall[3]} into hold/bubble/advance/clear.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while ex_wdata=32'hDEADBEEF and cnt_i=1 → all outputs go to 0 immediately, without a clock edge. Release rst, one edge with stall=0 → mem_wdata=32'hDEADBEEF, mem_valid=1.
- Pass-through: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_1234, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 → next edge mem_* match exactly, mem_valid=1, hilo_o=0, cnt_o=0.
- Multi-cycle hold:
  - Edge 1: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=1 → mem_valid=0, mem_wreg=0, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=1.
  - Edge 2: stall=0 → ex_* propagates, hilo_o=0, cnt_o=0.
- Full stall hold: load mem_wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles with ex_* changing → outputs unchanged throughout, mem_valid stays 1.
- Flush priority: flush=1 with stall=6'b001111 and hilo_i nonzero → all outputs 0 after the edge, including hilo_o and cnt_o.
- Bubble-no-write: random stall patterns over 1000 cycles → checker confirms mem_valid=0 implies mem_wreg=0 and mem_whilo=0, and that stall[3]=0 with stall[4]=1 never occurs.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// ============================================================================
// Module      : ex_mem_reg_pkg
// Description : Shared core constants and the EX/MEM register action decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_reg_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int REG_BUS_W        = 32;
    localparam int REG_ADD_BUS_W    = 5;
    localparam int DOUBLE_REG_BUS_W = 64;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_CLEAR   = 2'd3
    } pipe_act_e;

    // Execute running with memory stopped cannot occur; it falls into ADVANCE.
    function automatic pipe_act_e decode_act(input logic flush,
                                             input logic stall_mem,
                                             input logic stall_ex);
        if (flush) begin
            return ACT_CLEAR;
        end else if (stall_ex == STOP && stall_mem == NO_STOP) begin
            return ACT_BUBBLE;
        end else if (stall_ex == NO_STOP) begin
            return ACT_ADVANCE;
        end else begin
            return ACT_HOLD;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with stall/flush and held accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int REG_W  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    ex_wd,
    input  logic                 ex_wreg,
    input  logic [REG_W-1:0]     ex_wdata,
    input  logic                 ex_whilo,
    input  logic [REG_W-1:0]     ex_hi,
    input  logic [REG_W-1:0]     ex_lo,
    input  logic [2*REG_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]     cnt_i,
    output logic [ADDR_W-1:0]    mem_wd,
    output logic                 mem_wreg,
    output logic [REG_W-1:0]     mem_wdata,
    output logic                 mem_whilo,
    output logic [REG_W-1:0]     mem_hi,
    output logic [REG_W-1:0]     mem_lo,
    output logic                 mem_valid,
    output logic [2*REG_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]     cnt_o
);

    pipe_act_e w_act;
    logic      w_unused;

    assign w_act    = decode_act(flush, stall[STALL_MEM], stall[STALL_EX]);
    assign w_unused = &{1'b0, stall[5], stall[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            mem_wd    <= '0;
            mem_wreg  <= WRITE_DISABLE;
            mem_wdata <= '0;
            mem_whilo <= WRITE_DISABLE;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_valid <= 1'b0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else begin
            case (w_act)
                ACT_CLEAR: begin
                    mem_wd    <= '0;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= '0;
                    mem_whilo <= WRITE_DISABLE;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_valid <= 1'b0;
                    hilo_o    <= '0;
                    cnt_o     <= '0;
                end
                ACT_BUBBLE: begin
                    // Bubble downstream while execute keeps its partial product.
                    mem_wd    <= '0;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= '0;
                    mem_whilo <= WRITE_DISABLE;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_valid <= 1'b0;
                    hilo_o    <= hilo_i;
                    cnt_o     <= cnt_i;
                end
                ACT_ADVANCE: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_whilo <= ex_whilo;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_valid <= 1'b1;
                    hilo_o    <= '0;
                    cnt_o     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Directed-vector and random-stall bench for ex_mem_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks   = 0;
    int failures = 0;

    ex_mem_reg #(.REG_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("illegal stall combination %b", stall);
        end
    end

    typedef struct packed {
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_valid;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_wd, input logic e_wreg,
                           input logic [31:0] e_wdata, input logic e_whilo,
                           input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input logic e_valid, input logic [63:0] e_hilo,
                           input logic [1:0] e_cnt);
        chk({tag, " mem_wd"},    64'(mem_wd),    64'(e_wd));
        chk({tag, " mem_wreg"},  64'(mem_wreg),  64'(e_wreg));
        chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({tag, " mem_whilo"}, 64'(mem_whilo), 64'(e_whilo));
        chk({tag, " mem_hi"},    64'(mem_hi),    64'(e_hi));
        chk({tag, " mem_lo"},    64'(mem_lo),    64'(e_lo));
        chk({tag, " mem_valid"}, 64'(mem_valid), 64'(e_valid));
        chk({tag, " hilo_o"},    hilo_o,         e_hilo);
        chk({tag, " cnt_o"},     64'(cnt_o),     64'(e_cnt));
    endtask

    task automatic drive(input logic f, input logic [5:0] s, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata, input logic whilo,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic [63:0] hl, input logic [1:0] cn);
        flush = f; stall = s; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo; hilo_i = hl; cnt_i = cn;
    endtask

    // Reference state for the random phase.
    logic [4:0]  m_wd;
    logic        m_wreg, m_whilo, m_valid;
    logic [31:0] m_wdata, m_hi, m_lo;
    logic [63:0] m_hilo;
    logic [1:0]  m_cnt;

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);

        // Directed table, starting from the state left by the reset sequence
        // (mem_wdata=DEADBEEF, valid, accumulator clear).
        //            fl  stall       wd     wr  wdata          wh  hi             lo             hilo_i                   cnt    e_wd   e_wr e_wdata        e_wh e_hi           e_lo           e_v  e_hilo                   e_cnt
        vec[0]  = '{1'b0, 6'b000000, 5'd3,  1'b1, 32'h0000_1234, 1'b1, 32'h1,         32'h2,         64'h55,                  2'd2, 5'd3,  1'b1, 32'h0000_1234, 1'b1, 32'h1,         32'h2,         1'b1, 64'h0,                   2'd0};
        vec[1]  = '{1'b0, 6'b001111, 5'd7,  1'b1, 32'h77,        1'b1, 32'h9,         32'h8,         64'h0000_0001_FFFF_FFFE, 2'd1, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'h0000_0001_FFFF_FFFE, 2'd1};
        vec[2]  = '{1'b0, 6'b000000, 5'd7,  1'b1, 32'h77,        1'b0, 32'h0,         32'h0,         64'h123,                 2'd2, 5'd7,  1'b1, 32'h77,        1'b0, 32'h0,         32'h0,         1'b1, 64'h0,                   2'd0};
        vec[3]  = '{1'b0, 6'b000000, 5'd9,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA,      32'hBBBB,      64'h0,                   2'd0, 5'd9,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA,      32'hBBBB,      1'b1, 64'h0,                   2'd0};
        vec[4]  = '{1'b0, 6'b011111, 5'd1,  1'b0, 32'h1111_1111, 1'b0, 32'h1,         32'h1,         64'h1,                   2'd1, 5'd9,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA,      32'hBBBB,      1'b1, 64'h0,                   2'd0};
        vec[5]  = '{1'b0, 6'b011111, 5'd2,  1'b1, 32'h2222_2222, 1'b0, 32'h2,         32'h2,         64'h2,                   2'd2, 5'd9,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA,      32'hBBBB,      1'b1, 64'h0,                   2'd0};
        vec[6]  = '{1'b0, 6'b011111, 5'd3,  1'b0, 32'h3333_3333, 1'b1, 32'h3,         32'h3,         64'h3,                   2'd3, 5'd9,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA,      32'hBBBB,      1'b1, 64'h0,                   2'd0};
        vec[7]  = '{1'b0, 6'b001111, 5'd4,  1'b1, 32'h4,         1'b1, 32'h4,         32'h4,         64'hCAFE_0000_0000_BEEF, 2'd2, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'hCAFE_0000_0000_BEEF, 2'd2};
        vec[8]  = '{1'b0, 6'b011111, 5'd5,  1'b1, 32'h5,         1'b1, 32'h5,         32'h5,         64'h1,                   2'd1, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'hCAFE_0000_0000_BEEF, 2'd2};
        vec[9]  = '{1'b1, 6'b001111, 5'd6,  1'b1, 32'h6,         1'b1, 32'h6,         32'h6,         64'hFFFF,                2'd1, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'h0,                   2'd0};
        vec[10] = '{1'b0, 6'b001111, 5'd8,  1'b1, 32'h8,         1'b0, 32'h8,         32'h8,         64'h1234_5678_9ABC_DEF0, 2'd3, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'h1234_5678_9ABC_DEF0, 2'd3};
        vec[11] = '{1'b1, 6'b011111, 5'd8,  1'b1, 32'h8,         1'b1, 32'h8,         32'h8,         64'h1,                   2'd1, 5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 64'h0,                   2'd0};
        vec[12] = '{1'b0, 6'b000000, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0,         64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 64'h0,                   2'd0};
        vec[13] = '{1'b0, 6'b111111, 5'd2,  1'b1, 32'h2,         1'b0, 32'h2,         32'h2,         64'h2,                   2'd2, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 64'h0,                   2'd0};
        vec[14] = '{1'b0, 6'b000111, 5'd4,  1'b1, 32'h4444,      1'b0, 32'h44,        32'h55,        64'h9,                   2'd1, 5'd4,  1'b1, 32'h4444,      1'b0, 32'h44,        32'h55,        1'b1, 64'h0,                   2'd0};

        // Reset state, then load non-zero values so the async clear is visible.
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 6'b0, 5'd12, 1'b1, 32'h1357_9BDF, 1'b1, 32'h3, 32'h4, 64'h0, 2'd0);
        @(posedge clk); #1;
        chk("preload mem_wdata", 64'(mem_wdata), 64'h1357_9BDF);
        @(negedge clk);
        drive(1'b0, 6'b0, 5'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd1);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("post_rst mem_valid", 64'(mem_valid), 64'h1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vec[i].flush, vec[i].stall, vec[i].wd, vec[i].wreg, vec[i].wdata,
                  vec[i].whilo, vec[i].hi, vec[i].lo, vec[i].hilo, vec[i].cnt);
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vec[i].e_wd, vec[i].e_wreg, vec[i].e_wdata,
                    vec[i].e_whilo, vec[i].e_hi, vec[i].e_lo, vec[i].e_valid,
                    vec[i].e_hilo, vec[i].e_cnt);
        end

        // Random legal stall patterns against a behavioural reference.
        m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata; m_whilo = mem_whilo;
        m_hi = mem_hi; m_lo = mem_lo; m_valid = mem_valid; m_hilo = hilo_o; m_cnt = cnt_o;
        for (int n = 0; n < 1000; n++) begin
            logic [5:0] s;
            logic       f;
            @(negedge clk);
            s = 6'($urandom);
            if (!s[3]) s[4] = 1'b0;
            f = ($urandom_range(0, 15) == 0);
            drive(f, s, 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
                  $urandom, {$urandom, $urandom}, 2'($urandom));
            if (f) begin
                {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo, m_valid, m_hilo, m_cnt} = '0;
            end else if (s[3] && !s[4]) begin
                {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo, m_valid} = '0;
                m_hilo = hilo_i;
                m_cnt  = cnt_i;
            end else if (!s[3]) begin
                m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_whilo = ex_whilo;
                m_hi = ex_hi; m_lo = ex_lo; m_valid = 1'b1; m_hilo = '0; m_cnt = '0;
            end
            @(posedge clk); #1;
            if (!mem_valid) chk("bubble_no_write", 64'({mem_wreg, mem_whilo}), 64'h0);
            chk($sformatf("rand%0d mem", n),
                64'({m_wd, m_wreg, m_whilo, m_valid, m_cnt}),
                64'({m_wd, m_wreg, m_whilo, m_valid, m_cnt}) ^
                64'({mem_wd, mem_wreg, mem_whilo, mem_valid, cnt_o}) ^
                64'({m_wd, m_wreg, m_whilo, m_valid, m_cnt}));
            chk($sformatf("rand%0d data", n), {mem_hi, mem_wdata ^ mem_lo}, {m_hi, m_wdata ^ m_lo});
            chk($sformatf("rand%0d hilo", n), hilo_o, m_hilo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
